// File: rtl/led_pkg.sv
// Shared types and helpers for the LED source scheduler and for any
// consumer that needs to pull the displayed field out of a source word.
package led_pkg;

    // Scheduler FSM: ARB picks a winner, SHOW holds it for the dwell period.
    typedef enum logic {
        ARB  = 1'b0,
        SHOW = 1'b1
    } state_t;

    localparam int DEFAULT_DATA_BITS = 24;
    localparam int DEFAULT_LED_BITS  = 16;

    // Widest source word the helper below can handle.
    localparam int MAX_WORD_BITS = 64;
    typedef logic [MAX_WORD_BITS-1:0] word_t;

    // Returns the top led_bits of a data_bits-wide word, right-aligned.
    // Callers cast the result down to their own LED width.
    function automatic word_t led_field(input word_t word, input int data_bits,
                                        input int led_bits);
        word_t mask;
        mask = (word_t'(1) << led_bits) - word_t'(1);
        return (word >> (data_bits - led_bits)) & mask;
    endfunction

endpackage

// File: rtl/led_source_scheduler_if.sv
// Producer-side bundle: per-source valid/data in, one-hot ready back.
interface led_source_scheduler_if
    import led_pkg::*;
#(
    parameter int NUM_SRC   = 4,
    parameter int DATA_BITS = DEFAULT_DATA_BITS
);

    logic [NUM_SRC-1:0]                src_valid;
    logic [NUM_SRC-1:0][DATA_BITS-1:0] src_data;
    logic [NUM_SRC-1:0]                src_ready;

    // Producers drive words and watch for their ready bit.
    modport master (
        output src_valid,
        output src_data,
        input  src_ready
    );

    // The scheduler consumes words and issues the grant.
    modport slave (
        input  src_valid,
        input  src_data,
        output src_ready
    );

endinterface

// File: rtl/rr_arbiter.sv
// Purely combinational rotating-priority arbiter: the winner is the first
// requesting index strictly after 'last', searching upward with wrap.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    // Scan from the farthest candidate back to the nearest so the nearest
    // requester after 'last' is the one left in gnt_idx.
    always_comb begin
        int idx;
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned and no latch is inferred.
        gnt_idx = '0;
        idx     = 0;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(last) + k) % N;
            if (req[idx[IW-1:0]]) begin
                gnt_idx = idx[IW-1:0];
            end
        end
    end

    assign any = |req;
    assign gnt = any ? (N'(1) << gnt_idx) : '0;

endmodule

// File: rtl/led_source_scheduler.sv
// Time-shares the LED bank between NUM_SRC producers. In ARB one eligible
// source is granted and its word latched onto the LEDs; SHOW then holds the
// display for DWELL_CYCLES before arbitrating again. Pin mode restricts the
// eligible set to a single source.
module led_source_scheduler
    import led_pkg::*;
#(
    parameter  int NUM_SRC      = 4,
    parameter  int DATA_BITS    = DEFAULT_DATA_BITS,
    parameter  int LED_BITS     = DEFAULT_LED_BITS,
    parameter  int DWELL_CYCLES = 2 ** 24,
    localparam int IDX_BITS     = $clog2(NUM_SRC),
    localparam int CNT_BITS     = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    led_source_scheduler_if.slave bus,
    input  logic                  pin_en,
    input  logic [IDX_BITS-1:0]   pin_sel,
    output logic [LED_BITS-1:0]   leds,
    output logic [IDX_BITS-1:0]   active_src,
    output logic                  frame_strobe
);

    state_t               state_q;
    state_t               state_d;
    logic [CNT_BITS-1:0]  cnt_q;
    logic [IDX_BITS-1:0]  last_q;
    logic [NUM_SRC-1:0]   req;
    logic [NUM_SRC-1:0]   gnt;
    logic [IDX_BITS-1:0]  gnt_idx;
    logic                 any;
    logic                 fire;

    // Eligible set: all valid sources, or only the pinned one. An
    // out-of-range pin index leaves the set empty.
    always_comb begin
        req = bus.src_valid;
        if (pin_en) begin
            req = '0;
            if (int'(pin_sel) < NUM_SRC) begin
                req[pin_sel] = bus.src_valid[pin_sel];
            end
        end
    end

    rr_arbiter #(
        .N(NUM_SRC)
    ) u_arb (
        .req     (req),
        .last    (last_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    // The winner's valid is high by construction, so a grant in ARB is the
    // handshake itself.
    assign fire = (state_q == ARB) && any;

    // Ready is offered only in ARB and is held low while reset is asserted
    // so no producer sees a grant that cannot complete.
    always_comb begin
        bus.src_ready = '0;
        if (!rst && state_q == ARB) begin
            bus.src_ready = gnt;
        end
    end

    // Next-state logic: leave ARB on a grant, leave SHOW when the dwell
    // counter has run down to zero.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB:     if (any)           state_d = SHOW;
            SHOW:    if (cnt_q == '0)   state_d = ARB;
            default:                    state_d = ARB;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (rst) begin
            state_q <= ARB;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath: latch the granted word, remember the winner for rotation,
    // load and run down the dwell counter, and pulse the frame strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            leds         <= '0;
            active_src   <= '0;
            last_q       <= IDX_BITS'(NUM_SRC - 1);
            cnt_q        <= '0;
            frame_strobe <= 1'b0;
        end else begin
            frame_strobe <= fire;
            if (fire) begin
                leds       <= LED_BITS'(led_field(word_t'(bus.src_data[gnt_idx]),
                                                  DATA_BITS, LED_BITS));
                active_src <= gnt_idx;
                last_q     <= gnt_idx;
                cnt_q      <= CNT_BITS'(DWELL_CYCLES - 1);
            end else if (state_q == SHOW && cnt_q != '0) begin
                cnt_q <= cnt_q - CNT_BITS'(1);
            end
        end
    end

endmodule

// File: tb/tb_led_source_scheduler.sv
// Bench for led_source_scheduler. Two instances: A (4 sources, dwell 3)
// and B (3 sources, dwell 1). A per-cycle behavioural model predicts every
// output; directed phases add literal expectations on top.
module tb_led_source_scheduler;

    localparam int N_A = 4;
    localparam int N_B = 3;
    localparam int D_A = 3;
    localparam int D_B = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    led_source_scheduler_if #(.NUM_SRC(N_A), .DATA_BITS(24)) ifa ();
    led_source_scheduler_if #(.NUM_SRC(N_B), .DATA_BITS(24)) ifb ();

    logic        pin_en_a, pin_en_b;
    logic [1:0]  pin_sel_a, pin_sel_b;
    logic [15:0] leds_a, leds_b;
    logic [1:0]  act_a, act_b;
    logic        fs_a, fs_b;

    led_source_scheduler #(
        .NUM_SRC(N_A), .DATA_BITS(24), .LED_BITS(16), .DWELL_CYCLES(D_A)
    ) dut_a (
        .clk(clk), .rst(rst), .bus(ifa), .pin_en(pin_en_a), .pin_sel(pin_sel_a),
        .leds(leds_a), .active_src(act_a), .frame_strobe(fs_a)
    );

    led_source_scheduler #(
        .NUM_SRC(N_B), .DATA_BITS(24), .LED_BITS(16), .DWELL_CYCLES(D_B)
    ) dut_b (
        .clk(clk), .rst(rst), .bus(ifb), .pin_en(pin_en_b), .pin_sel(pin_sel_b),
        .leds(leds_b), .active_src(act_b), .frame_strobe(fs_b)
    );

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    // Strobe monitors: displayed value, source and cycle of each new frame.
    logic [15:0] la[$];
    logic [15:0] lb[$];
    int aa[$];
    int ab[$];
    int qa[$];
    int qb[$];
    int hs_a = 0, hs_b = 0, sa = 0, sb = 0;

    // Behavioural model state, index 0 = A, 1 = B.
    bit          m_show[2];
    int          m_left[2];
    int          m_last[2];
    int          m_active[2];
    logic [15:0] m_leds[2];
    bit          m_strobe[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    function automatic int num_of(input int i);
        return (i == 0) ? N_A : N_B;
    endfunction

    function automatic int dwell_of(input int i);
        return (i == 0) ? D_A : D_B;
    endfunction

    // Winner by the rule: first eligible index after the last grant, wrapping.
    function automatic int win(input int i);
        int n;
        int idx;
        logic [7:0] v;
        bit pe;
        int ps;
        n = num_of(i);
        if (i == 0) begin
            v = {4'b0, ifa.src_valid};
            pe = pin_en_a;
            ps = int'(pin_sel_a);
        end else begin
            v = {5'b0, ifb.src_valid};
            pe = pin_en_b;
            ps = int'(pin_sel_b);
        end
        for (int k = 1; k <= n; k++) begin
            idx = (m_last[i] + k) % n;
            if (v[idx[2:0]] && (!pe || ps == idx)) return idx;
        end
        return -1;
    endfunction

    function automatic logic [23:0] word(input int i, input int w);
        return (i == 0) ? ifa.src_data[w[1:0]] : ifb.src_data[w[1:0]];
    endfunction

    function automatic logic [31:0] exp_ready(input int i);
        int w;
        if (rst || m_show[i]) return '0;
        w = win(i);
        if (w < 0) return '0;
        return 32'(1) << w;
    endfunction

    always @(posedge clk) cycle <= cycle + 1;

    // Model: a grant starts a display of dwell_of(i) hold cycles.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_show[i]   <= 1'b0;
                m_left[i]   <= 0;
                m_active[i] <= 0;
                m_leds[i]   <= '0;
                m_strobe[i] <= 1'b0;
                m_last[i]   <= num_of(i) - 1;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_show[i]) begin
                    m_strobe[i] <= 1'b0;
                    m_left[i]   <= m_left[i] - 1;
                    if (m_left[i] == 1) m_show[i] <= 1'b0;
                end else if (win(i) >= 0) begin
                    m_strobe[i] <= 1'b1;
                    m_leds[i]   <= 16'(word(i, win(i)) >> 8);
                    m_active[i] <= win(i);
                    m_last[i]   <= win(i);
                    m_show[i]   <= 1'b1;
                    m_left[i]   <= dwell_of(i);
                end else begin
                    m_strobe[i] <= 1'b0;
                end
            end
        end
    end

    // Compare every output against the model and record frames/handshakes.
    always @(negedge clk) begin
        if (cycle > 0) begin
            check("leds_a",   32'(leds_a),          32'(m_leds[0]));
            check("active_a", 32'(act_a),           32'(m_active[0]));
            check("strobe_a", 32'(fs_a),            32'(m_strobe[0]));
            check("ready_a",  32'(ifa.src_ready),   exp_ready(0));
            check("onehot_a", 32'($onehot0(ifa.src_ready)), 32'(1));
            check("leds_b",   32'(leds_b),          32'(m_leds[1]));
            check("active_b", 32'(act_b),           32'(m_active[1]));
            check("strobe_b", 32'(fs_b),            32'(m_strobe[1]));
            check("ready_b",  32'(ifb.src_ready),   exp_ready(1));
            check("onehot_b", 32'($onehot0(ifb.src_ready)), 32'(1));
            if (!rst) begin
                if (fs_a) begin
                    la.push_back(leds_a); aa.push_back(int'(act_a)); qa.push_back(cycle); sa++;
                end
                if (fs_b) begin
                    lb.push_back(leds_b); ab.push_back(int'(act_b)); qb.push_back(cycle); sb++;
                end
                if (|(ifa.src_valid & ifa.src_ready)) hs_a++;
                if (|(ifb.src_valid & ifb.src_ready)) hs_b++;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_q();
        la.delete(); aa.delete(); qa.delete();
        lb.delete(); ab.delete(); qb.delete();
    endtask

    task automatic wait_strobes(input int inst, input int n, input int budget);
        int spent;
        spent = 0;
        while (((inst == 0) ? la.size() : lb.size()) < n && spent < budget) begin
            cyc(1);
            spent++;
        end
        if (((inst == 0) ? la.size() : lb.size()) < n) begin
            checks++;
            failures++;
            $display("FAIL timeout: dut%0d produced fewer than %0d frames", inst, n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rr_exp [5];
        int hs_snap;
        rr_exp = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h1111};

        ifa.src_valid = '0; ifa.src_data = '0; pin_en_a = 1'b0; pin_sel_a = '0;
        ifb.src_valid = '0; ifb.src_data = '0; pin_en_b = 1'b0; pin_sel_b = '0;

        // Reset values.
        cyc(3);
        check("rst_leds",   32'(leds_a),        32'h0);
        check("rst_active", 32'(act_a),         32'h0);
        check("rst_strobe", 32'(fs_a),          32'h0);
        check("rst_ready",  32'(ifa.src_ready), 32'h0);

        // Grant 24'hABCD12, then reset mid-SHOW.
        ifa.src_data[0] = 24'hABCD12;
        ifa.src_valid   = 4'b0001;
        rst = 1'b0;
        cyc(2);
        check("abcd_leds", 32'(leds_a), 32'hABCD);
        rst = 1'b1;
        #1;
        check("midrst_leds",   32'(leds_a),        32'h0);
        check("midrst_ready",  32'(ifa.src_ready), 32'h0);
        check("midrst_active", 32'(act_a),         32'h0);

        // Round robin from release: 1111,2222,3333,4444,1111 spaced 4.
        for (int i = 0; i < N_A; i++)
            ifa.src_data[i] = {{4{4'(i + 1)}}, 8'($urandom_range(255))};
        ifa.src_valid = 4'b1111;
        cyc(1);
        clear_q();
        rst = 1'b0;
        wait_strobes(0, 5, 40);
        if (la.size() >= 5) begin
            check("rr_first_src", 32'(aa[0]), 32'h0);
            for (int k = 0; k < 5; k++) check($sformatf("rr_leds%0d", k), 32'(la[k]), 32'(rr_exp[k]));
            for (int k = 0; k < 4; k++) check($sformatf("rr_gap%0d", k), 32'(qa[k + 1] - qa[k]), 32'd4);
        end

        // Sparse: src2 alone, then src1 joins during SHOW.
        ifa.src_valid = 4'b0100;
        cyc(1);
        clear_q();
        wait_strobes(0, 1, 20);
        ifa.src_valid = 4'b0110;
        wait_strobes(0, 3, 20);
        if (la.size() >= 3) begin
            check("sparse_0", 32'(la[0]), 32'h3333);
            check("sparse_1", 32'(la[1]), 32'h2222);
            check("sparse_src1", 32'(aa[1]), 32'h1);
            check("sparse_2", 32'(la[2]), 32'h3333);
        end

        // Pin mode on source 3.
        pin_en_a = 1'b1; pin_sel_a = 2'd3; ifa.src_valid = 4'b1111;
        cyc(1);
        clear_q();
        wait_strobes(0, 4, 40);
        if (la.size() >= 4) begin
            for (int k = 0; k < 4; k++) check($sformatf("pin_leds%0d", k), 32'(la[k]), 32'h4444);
            for (int k = 0; k < 3; k++) check($sformatf("pin_gap%0d", k), 32'(qa[k + 1] - qa[k]), 32'd4);
        end

        // Idle hold after a 24'hBEEF00 frame.
        pin_en_a = 1'b0; ifa.src_data[0] = 24'hBEEF00; ifa.src_valid = 4'b0001;
        cyc(1);
        clear_q();
        wait_strobes(0, 1, 20);
        ifa.src_valid = 4'b0000;
        hs_snap = hs_a;
        cyc(100);
        check("idle_frames",  32'(la.size()), 32'd1);
        check("idle_leds",    32'(leds_a),    32'hBEEF);
        check("idle_strobe",  32'(fs_a),      32'h0);
        check("idle_hs",      32'(hs_a - hs_snap), 32'd0);

        // Minimum dwell on B: sources 0 and 1 alternate every 2 cycles.
        ifb.src_data[0] = 24'h5A5A01; ifb.src_data[1] = 24'hC3C302; ifb.src_data[2] = 24'h777703;
        ifb.src_valid = 3'b011;
        cyc(1);
        clear_q();
        wait_strobes(1, 4, 20);
        if (lb.size() >= 4) begin
            check("min_leds0", 32'(lb[0]), 32'h5A5A);
            check("min_leds1", 32'(lb[1]), 32'hC3C3);
            for (int k = 0; k < 4; k++) check($sformatf("min_src%0d", k), 32'(ab[k]), 32'(k % 2));
            for (int k = 0; k < 3; k++) check($sformatf("min_gap%0d", k), 32'(qb[k + 1] - qb[k]), 32'd2);
        end

        // Out-of-range pin on B: no grants, LEDs hold the last frame.
        ifb.src_valid = 3'b010;
        cyc(1);
        clear_q();
        wait_strobes(1, 1, 10);
        pin_en_b = 1'b1; pin_sel_b = 2'd3; ifb.src_valid = 3'b111;
        cyc(1);
        clear_q();
        cyc(20);
        check("oor_frames", 32'(lb.size()),    32'd0);
        check("oor_leds",   32'(leds_b),       32'hC3C3);
        check("oor_ready",  32'(ifb.src_ready), 32'h0);

        // Random traffic on both instances, checked by the model each cycle.
        for (int t = 0; t < 300; t++) begin
            ifa.src_valid = 4'($urandom);
            ifb.src_valid = 3'($urandom);
            for (int i = 0; i < N_A; i++) ifa.src_data[i] = 24'($urandom);
            for (int i = 0; i < N_B; i++) ifb.src_data[i] = 24'($urandom);
            pin_en_a  = ($urandom_range(7) == 0);
            pin_en_b  = ($urandom_range(7) == 0);
            pin_sel_a = 2'($urandom);
            pin_sel_b = 2'($urandom);
            cyc(1);
        end

        // Drain and compare handshake and frame totals.
        ifa.src_valid = '0; ifb.src_valid = '0; pin_en_a = 1'b0; pin_en_b = 1'b0;
        cyc(6);
        check("hs_vs_frames_a", 32'(hs_a), 32'(sa));
        check("hs_vs_frames_b", 32'(hs_b), 32'(sb));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
